// File: rtl/display_pkg.sv
// Shared display geometry, framebuffer sizing and pixel-writer state encoding.
package display_pkg;

    localparam int unsigned H_PIXELS       = 640;
    localparam int unsigned V_LINES        = 480;
    localparam int unsigned WORDS_PER_LINE = H_PIXELS / 32;
    localparam int unsigned FB_WORDS       = WORDS_PER_LINE * V_LINES;
    localparam int unsigned FB_ADDR_W      = 15;
    localparam int unsigned X_W            = 10;
    localparam int unsigned Y_W            = 9;

    typedef enum logic {
        STREAM = 1'b0,
        FILL   = 1'b1
    } state_e;

endpackage

// File: rtl/fb_pixel_writer.sv
// Packs a raster 1-bit pixel stream into 32-pixel framebuffer words and
// provides a whole-screen fill sequencer sharing the same write port.
module fb_pixel_writer
    import display_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 px_valid,
    output logic                 px_ready,
    input  logic                 px_data,
    input  logic                 px_sof,
    input  logic                 px_eol,
    input  logic                 fill_start,
    input  logic                 fill_value,
    output logic                 busy,
    output logic                 write,
    output logic [FB_ADDR_W-1:0] address,
    output logic [31:0]          writedata,
    output logic                 frame_done,
    output logic                 line_err
);

    state_e               state_q, state_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [FB_ADDR_W-1:0] base_q, base_d;
    logic [31:0]          pack_q, pack_d;
    logic                 write_q, write_d;
    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 busy_q, busy_d;
    logic                 fd_q, fd_d;
    logic                 le_q, le_d;

    logic [X_W-1:0]       cx;
    logic [Y_W-1:0]       cy;
    logic [FB_ADDR_W-1:0] cbase;
    logic [31:0]          cpack;
    logic [31:0]          word;
    logic                 at_last_px;
    logic                 line_end;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        base_d     = base_q;
        pack_d     = pack_q;
        write_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        fd_d       = 1'b0;
        le_d       = 1'b0;
        cx         = x_q;
        cy         = y_q;
        cbase      = base_q;
        cpack      = pack_q;
        word       = '0;
        at_last_px = 1'b0;
        line_end   = 1'b0;

        case (state_q)
            STREAM: begin
                busy_d = 1'b0;
                if (fill_start) begin
                    // The fill sequencer reuses the address/data output registers as its counter.
                    state_d = FILL;
                    x_d     = '0;
                    y_d     = '0;
                    base_d  = '0;
                    pack_d  = '0;
                    write_d = 1'b1;
                    addr_d  = '0;
                    wdata_d = {32{fill_value}};
                    busy_d  = 1'b1;
                end else if (px_valid) begin
                    if (px_sof) begin
                        le_d  = (x_q != '0) || (y_q != '0);
                        cx    = '0;
                        cy    = '0;
                        cbase = '0;
                        cpack = '0;
                    end
                    word       = cpack | (32'(px_data) << cx[4:0]);
                    at_last_px = (cx == X_W'(H_PIXELS - 1));
                    line_end   = px_eol || at_last_px;
                    if ((px_eol && !at_last_px && !px_sof) || (!px_eol && at_last_px))
                        le_d = 1'b1;

                    if ((cx[4:0] == 5'd31) || line_end) begin
                        write_d = 1'b1;
                        addr_d  = cbase + FB_ADDR_W'(cx[X_W-1:5]);
                        wdata_d = word;
                        pack_d  = '0;
                    end else begin
                        pack_d  = word;
                    end

                    if (line_end) begin
                        x_d = '0;
                        if (cy == Y_W'(V_LINES - 1)) begin
                            fd_d   = 1'b1;
                            y_d    = '0;
                            base_d = '0;
                        end else begin
                            y_d    = cy + Y_W'(1);
                            base_d = cbase + FB_ADDR_W'(WORDS_PER_LINE);
                        end
                    end else begin
                        x_d    = cx + X_W'(1);
                        y_d    = cy;
                        base_d = cbase;
                    end
                end
            end
            FILL: begin
                if (addr_q == FB_ADDR_W'(FB_WORDS - 1)) begin
                    state_d = STREAM;
                    busy_d  = 1'b0;
                end else begin
                    write_d = 1'b1;
                    addr_d  = addr_q + FB_ADDR_W'(1);
                    busy_d  = 1'b1;
                end
            end
            default: state_d = STREAM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STREAM;
            x_q     <= '0;
            y_q     <= '0;
            base_q  <= '0;
            pack_q  <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
            le_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            base_q  <= base_d;
            pack_q  <= pack_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
            le_q    <= le_d;
        end
    end

    assign px_ready   = (state_q == STREAM);
    assign busy       = busy_q;
    assign write      = write_q;
    assign address    = addr_q;
    assign writedata  = wdata_q;
    assign frame_done = fd_q;
    assign line_err   = le_q;

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Upstream stage of the VGA display: converts a raster-order 1-bit pixel stream into 32-pixel words and drives the display framebuffer's write port (data, write, 15-bit word address). Framebuffer layout is fixed: 640×480 pixels, 20 words per row, word address = y·20 + x/32, pixel x at bit x[4:0], 1 = white. Also provides a whole-screen fill engine for clear/set.

## Interface
- H_PIXELS, 640, pixels per line (multiple of 32)
- V_LINES, 480, lines per frame
- WORDS_PER_LINE, H_PIXELS/32 = 20, row stride in words
- FB_WORDS, WORDS_PER_LINE·V_LINES = 9600, words written by a fill
- clk  in  1  system clock (50 MHz domain, same as the display)
- reset  in  1  synchronous, active-high
- px_valid  in  1  pixel beat valid
- px_ready  out  1  pixel beat accepted when px_valid && px_ready
- px_data  in  1  pixel value
- px_sof  in  1  beat is pixel (0,0) of a frame
- px_eol  in  1  beat is last pixel of its line
- fill_start  in  1  one-cycle request to fill whole framebuffer
- fill_value  in  1  fill colour, sampled with fill_start
- busy  out  1  fill in progress
- write  out  1  framebuffer write strobe
- address  out  15  framebuffer word address
- writedata  out  32  framebuffer word
- frame_done  out  1  one-cycle pulse with the final write of line V_LINES-1
- line_err  out  1  one-cycle pulse on a malformed line/frame

## Operation
- States: STREAM, FILL. Reset → STREAM; x=0, y=0, line_base=0, pack register=0.
- px_ready = (state == STREAM). Throughput one pixel per cycle; no backpressure from framebuffer (write always accepted).
- Accepted beat: pack[x[4:0]] ← px_data; x increments. line_base tracked incrementally (+WORDS_PER_LINE per line), no multiplier.
- Word emitted when accepted beat has x[4:0]=31 or ends the line: address = line_base + x[9:5], writedata = pack with the new bit merged, unfilled higher bits 0; pack cleared.
- Line end: px_eol, or x = H_PIXELS-1. Then x←0, y←y+1, line_base += 20.
  - px_eol with x < H_PIXELS-1 (short line): partial word written, remaining words of row untouched, line_err pulse.
  - x = H_PIXELS-1 without px_eol: line ends anyway, line_err pulse.
- End of line V_LINES-1: frame_done pulses with that write; y←0, line_base←0.
- px_sof on accepted beat: forces x=0, y=0 before storing the pixel. If a partial word is pending or (x,y)≠(0,0), pending bits discarded unwritten, line_err pulse. sof+eol on one beat = valid 1-pixel line.
- fill_start in STREAM: captures fill_value, discards pending partial word, x=y=line_base=0, → FILL. A pixel accepted in the same cycle is dropped. fill_start in FILL ignored.
- FILL: writes address 0..FB_WORDS-1, one per cycle, writedata = {32{fill_value}}; after address FB_WORDS-1 → STREAM. No frame_done for fills.

## Timing
- All outputs except px_ready registered. Reset values: write=0, address=0, writedata=0, busy=0, frame_done=0, line_err=0; px_ready=1 (state STREAM).
- Write latency: write/address/writedata valid the cycle after the accepting edge of the word-completing beat.
- Back-to-back line ends (1-pixel lines) produce writes on consecutive cycles.
- fill_start at edge N: busy=1 and first fill write (address 0) in cycle N+1; last write (9599) in cycle N+9600; busy=0, px_ready=1 in cycle N+9601.
- Reset mid-frame or mid-fill: returns to STREAM next cycle, pending word discarded, no write issued.

## Structure
- Shared package display_pkg: H_PIXELS, V_LINES, WORDS_PER_LINE, FB_WORDS, FB_ADDR_W=15, state enum {STREAM, FILL}; the display stage imports the same constants.
- Single module; packing, counters and fill sequencer inline, no sub-module.

## Test plan
- Full frame of alternating 1/0 with correct sof/eol → 9600 writes, address k gets 32'h5555_5555, frame_done once with address 9599.
- Line 0 of 40 pixels, eol on x=39, all 1 → writes (0, 32'hFFFF_FFFF), (1, 32'h0000_00FF), line_err pulse; next line writes to address 20.
- 700 pixels without eol → line ends at x=639 with line_err, pixel 640 lands at address 20 bit 0.
- sof after 10 pixels of line 3 → no write for those 10, line_err, next word written to address 0.
- fill_start with fill_value=1 mid-line → pixel stalled, 9600 writes of 32'hFFFF_FFFF at addresses 0..9599, busy high exactly 9600 cycles, then stream restarts at address 0.
- Reset asserted during fill at address 500 → write=0 next cycle, px_ready=1, busy=0.
